// File: rtl/config_regmap_ctrl_if.sv
// -----------------------------------------------------------------------------
// config_regmap_ctrl_if
//
// Byte-stream bus between the UART pair and the configuration controller.
//   rx_valid / rx_data : one-cycle strobe plus byte from the UART receiver
//   tx_ready           : UART transmitter can accept a byte
//   tx_valid / tx_data : response byte offered to the UART transmitter
//
// Modports:
//   master : the UART side (drives received bytes and tx_ready)
//   slave  : the controller side (consumes received bytes, offers tx bytes)
// -----------------------------------------------------------------------------
interface config_regmap_ctrl_if;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       tx_ready;
    logic       tx_valid;
    logic [7:0] tx_data;

    modport master (
        output rx_valid,
        output rx_data,
        output tx_ready,
        input  tx_valid,
        input  tx_data
    );

    modport slave (
        input  rx_valid,
        input  rx_data,
        input  tx_ready,
        output tx_valid,
        output tx_data
    );
endinterface

// File: rtl/config_regmap_ctrl.sv
// -----------------------------------------------------------------------------
// config_regmap_ctrl
//
// Packet decoder and configuration register file. Parses 4-byte packets
// (HDR, ADDR, DATA, CHK) from the UART receiver, executes register writes,
// reads and soft resets, and returns 4-byte read responses through the UART
// transmitter. Supports chip addressing with broadcast ID 0xF, per-register
// reset defaults, XOR checksum, an inter-byte timeout and error pulses.
//
// Parameters:
//   NUMREGS    : number of 8-bit configuration registers (1..255)
//   RESET_VALS : flat default values, register k at [8k+7:8k]
//   TIMEOUT    : idle cycles between bytes of one packet that abort it
//
// Ports:
//   clk         : core clock, rising edge
//   reset       : asynchronous, active-high reset
//   chip_id     : strapped chip address (0xF is the broadcast ID)
//   bus         : UART byte stream (slave modport)
//   config_bits : flat register contents, register k at [8k+7:8k]
//   cmd_error   : one-cycle pulse when a packet or byte is rejected
//   busy        : high whenever the controller is not idle
// -----------------------------------------------------------------------------
module config_regmap_ctrl #(
    parameter int                   NUMREGS    = 64,
    parameter logic [NUMREGS*8-1:0] RESET_VALS = '0,
    parameter int                   TIMEOUT    = 1023
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [3:0]             chip_id,
    config_regmap_ctrl_if.slave    bus,
    output logic [NUMREGS*8-1:0]   config_bits,
    output logic                   cmd_error,
    output logic                   busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_CHK,
        S_EXEC,
        S_RESP
    } state_t;

    // What EXEC will do with the packet; decided when the CHK byte arrives
    // so that cmd_error can already be high during the EXEC cycle.
    typedef enum logic [2:0] {
        ACT_DISCARD,
        ACT_ERROR,
        ACT_WRITE,
        ACT_SRST,
        ACT_READ
    } act_t;

    localparam logic [1:0]  OP_WRITE  = 2'b00;
    localparam logic [1:0]  OP_READ   = 2'b01;
    localparam logic [1:0]  OP_SRST   = 2'b10;
    localparam logic [3:0]  BCAST_ID  = 4'hF;
    localparam logic [8:0]  NUMREGS_W = 9'(NUMREGS);
    // The gap counter value on which one more idle cycle makes it TIMEOUT.
    localparam logic [15:0] GAP_LAST  = 16'(TIMEOUT - 1);

    function automatic act_t classify(input logic [7:0] hdr,
                                      input logic [7:0] addr,
                                      input logic [7:0] data,
                                      input logic [7:0] chk,
                                      input logic [3:0] id);
        logic bcast;
        logic ours;
        logic addr_op;
        act_t act;
        bcast   = (hdr[7:4] == BCAST_ID);
        ours    = (hdr[7:4] == id) || bcast;
        addr_op = (hdr[3:2] == OP_WRITE) || (hdr[3:2] == OP_READ);
        if (!ours) begin
            act = ACT_DISCARD;
        end else if ((chk != (hdr ^ addr ^ data)) || (hdr[1:0] != 2'b00) ||
                     (hdr[3:2] == 2'b11) ||
                     (addr_op && ({1'b0, addr} >= NUMREGS_W))) begin
            act = ACT_ERROR;
        end else if (hdr[3:2] == OP_WRITE) begin
            act = ACT_WRITE;
        end else if (hdr[3:2] == OP_SRST) begin
            act = ACT_SRST;
        end else begin
            // Broadcast reads are dropped so several chips never drive TX.
            act = bcast ? ACT_DISCARD : ACT_READ;
        end
        return act;
    endfunction

    state_t      state_q,     state_d;
    act_t        act_q,       act_d;
    logic [7:0]  hdr_q,       hdr_d;
    logic [7:0]  addr_q,      addr_d;
    logic [7:0]  data_q,      data_d;
    logic [15:0] gap_q,       gap_d;
    logic [1:0]  tx_idx_q,    tx_idx_d;
    logic [7:0]  rd_byte_q,   rd_byte_d;
    logic        tx_valid_q,  tx_valid_d;
    logic [7:0]  tx_data_q,   tx_data_d;
    logic        cmd_error_q, cmd_error_d;
    logic        busy_q,      busy_d;
    logic [7:0]  regs_q [NUMREGS];
    logic [7:0]  regs_d [NUMREGS];

    logic [7:0]  rd_mux;
    logic [7:0]  resp_hdr;
    logic [1:0]  next_idx;
    logic [7:0]  next_byte;

    // Read mux written as a compare loop so the 8-bit ADDR never has to be
    // narrowed to the register index width.
    always_comb begin
        rd_mux = 8'h00;
        for (int k = 0; k < NUMREGS; k++) begin
            if (addr_q == 8'(k)) rd_mux = regs_q[k];
        end
    end

    // Response bytes: header, ADDR, sampled register value, XOR of the three.
    assign resp_hdr = {chip_id, 4'b0100};
    assign next_idx = tx_idx_q + 2'd1;

    always_comb begin
        case (next_idx)
            2'd1:    next_byte = addr_q;
            2'd2:    next_byte = rd_byte_q;
            2'd3:    next_byte = resp_hdr ^ addr_q ^ rd_byte_q;
            default: next_byte = resp_hdr;
        endcase
    end

    // NOTE: every signal gets its hold/idle value before the case statement,
    // so no path through the logic leaves one unassigned and no latch forms.
    always_comb begin
        state_d     = state_q;
        act_d       = act_q;
        hdr_d       = hdr_q;
        addr_d      = addr_q;
        data_d      = data_q;
        gap_d       = gap_q;
        tx_idx_d    = tx_idx_q;
        rd_byte_d   = rd_byte_q;
        tx_valid_d  = tx_valid_q;
        tx_data_d   = tx_data_q;
        cmd_error_d = 1'b0;
        regs_d      = regs_q;

        case (state_q)
            S_IDLE: begin
                gap_d = 16'd0;
                if (bus.rx_valid) begin
                    hdr_d   = bus.rx_data;
                    state_d = S_ADDR;
                end
            end

            S_ADDR, S_DATA, S_CHK: begin
                if (bus.rx_valid) begin
                    gap_d = 16'd0;
                    case (state_q)
                        S_ADDR: begin
                            addr_d  = bus.rx_data;
                            state_d = S_DATA;
                        end
                        S_DATA: begin
                            data_d  = bus.rx_data;
                            state_d = S_CHK;
                        end
                        default: begin
                            act_d       = classify(hdr_q, addr_q, data_q,
                                                   bus.rx_data, chip_id);
                            cmd_error_d = (act_d == ACT_ERROR);
                            state_d     = S_EXEC;
                        end
                    endcase
                end else if (gap_q == GAP_LAST) begin
                    // This idle cycle brings the gap to TIMEOUT: abort.
                    gap_d       = 16'd0;
                    cmd_error_d = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    gap_d = gap_q + 16'd1;
                end
            end

            S_EXEC: begin
                cmd_error_d = bus.rx_valid;
                state_d     = S_IDLE;
                case (act_q)
                    ACT_WRITE: begin
                        for (int k = 0; k < NUMREGS; k++) begin
                            if (addr_q == 8'(k)) regs_d[k] = data_q;
                        end
                    end
                    ACT_SRST: begin
                        for (int k = 0; k < NUMREGS; k++) begin
                            regs_d[k] = RESET_VALS[8*k +: 8];
                        end
                    end
                    ACT_READ: begin
                        // Sample now so the queued response is fixed.
                        rd_byte_d  = rd_mux;
                        tx_idx_d   = 2'd0;
                        tx_valid_d = 1'b1;
                        tx_data_d  = resp_hdr;
                        state_d    = S_RESP;
                    end
                    default: ;
                endcase
            end

            S_RESP: begin
                cmd_error_d = bus.rx_valid;
                if (tx_valid_q && bus.tx_ready) begin
                    if (tx_idx_q == 2'd3) begin
                        tx_valid_d = 1'b0;
                        tx_data_d  = 8'h00;
                        state_d    = S_IDLE;
                    end else begin
                        tx_idx_d  = next_idx;
                        tx_data_d = next_byte;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // NOTE: the register file is built from flops with a reset rather than a
    // RAM, because every bit drives an analog net and must come up at its
    // default the moment reset asserts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            act_q       <= ACT_DISCARD;
            hdr_q       <= 8'h00;
            addr_q      <= 8'h00;
            data_q      <= 8'h00;
            gap_q       <= 16'd0;
            tx_idx_q    <= 2'd0;
            rd_byte_q   <= 8'h00;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= 8'h00;
            cmd_error_q <= 1'b0;
            busy_q      <= 1'b0;
            for (int k = 0; k < NUMREGS; k++) begin
                regs_q[k] <= RESET_VALS[8*k +: 8];
            end
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // computed from the previous state, independent of statement order.
            state_q     <= state_d;
            act_q       <= act_d;
            hdr_q       <= hdr_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            gap_q       <= gap_d;
            tx_idx_q    <= tx_idx_d;
            rd_byte_q   <= rd_byte_d;
            tx_valid_q  <= tx_valid_d;
            tx_data_q   <= tx_data_d;
            cmd_error_q <= cmd_error_d;
            busy_q      <= busy_d;
            regs_q      <= regs_d;
        end
    end

    for (genvar g = 0; g < NUMREGS; g++) begin : g_cfg
        assign config_bits[8*g +: 8] = regs_q[g];
    end

    assign bus.tx_valid = tx_valid_q;
    assign bus.tx_data  = tx_data_q;
    assign cmd_error    = cmd_error_q;
    assign busy         = busy_q;

endmodule
